nibble_serial_adder: RTL and testbench

- Multi-cycle WIDTH-bit adder/subtractor that computes one 4-bit nibble per clock through an internal 4-bit carry-look-ahead slice, LSB nibble first.
- Carry-out of each nibble is registered and becomes the next nibble's carry-in.
- Sits in the ALU datapath and trades latency for area against a full-width parallel adder.
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/nibble_serial_adder_if.sv | 27 ++
 rtl/nibble_serial_adder.sv | 95 +++++++++
 tb/tb_nibble_serial_adder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - operand/result handshake bundle for the nibble-serial adder
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle adder/subtractor, one 4-bit CLA nibble per clock
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;

  logic [3:0]       an, bn, g, p, sn;
  logic [4:0]       c;
  logic [WIDTH-1:0] sum_next;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.overflow  = ovf_r;
  assign bus.zero      = zero_r;

  // 4-bit carry-look-ahead slice on the current nibble, merged into the running result
  always_comb begin
    an = a_reg[4*int'(k) +: 4];
    bn = b_reg[4*int'(k) +: 4];
    g  = an & bn;
    p  = an ^ bn;
    c[0] = carry;
    c[1] = g[0] | (p[0] & carry);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & carry);
    sn = p ^ c[3:0];
    sum_next = sum_r;
    sum_next[4*int'(k) +: 4] = sn;
  end

  // Control FSM: accept operands, step one nibble per cycle, hold the result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      carry  <= 1'b0;
      k      <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg <= bus.a;
            b_reg <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub ? 1'b1 : bus.cin;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_r <= sum_next;
          carry <= c[4];
          k     <= k + KW'(1);
          if (k == KW'(NIB - 1)) begin
            // c[3] is the carry into the MSB, c[4] the carry out of it
            cout_r <= c[4];
            ovf_r  <= c[4] ^ c[3];
            zero_r <= (sum_next == '0);
            k      <= '0;
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - randomized self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  nibble_serial_adder_if #(.WIDTH(16)) if16 ();
  nibble_serial_adder_if #(.WIDTH(8))  if8 ();

  nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  nibble_serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain modular arithmetic; signed overflow from operand/result signs
  task automatic ref_op(input int w, input longint unsigned a, input longint unsigned b,
                        input logic sub, input logic cin,
                        output longint unsigned s, output logic co, output logic ov,
                        output logic z);
    longint unsigned mask, bb, t;
    logic sa, sb, sr;
    mask = (64'd1 << w) - 1;
    bb   = sub ? (~b & mask) : (b & mask);
    t    = (a & mask) + bb + (sub ? 64'd1 : longint'(cin));
    s    = t & mask;
    co   = t[w];
    sa   = a[w-1];
    sb   = bb[w-1];
    sr   = s[w-1];
    ov   = (sa == sb) && (sr != sa);
    z    = (s == 0);
  endtask

  task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic cin, output logic [15:0] s, output logic co,
                         output logic ov, output logic z, output int lat);
    int w;
    w = 0;
    while (!if16.in_ready && w < 20) begin @(posedge clk); #1; w++; end
    @(negedge clk);
    if16.in_valid = 1'b1; if16.a = a; if16.b = b; if16.sub = sub; if16.cin = cin;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    if16.a = 16'($urandom); if16.b = 16'($urandom);
    if16.sub = 1'($urandom); if16.cin = 1'($urandom);
    lat = 0;
    while (!if16.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    s = if16.sum; co = if16.cout; ov = if16.overflow; z = if16.zero;
    @(negedge clk); if16.out_ready = 1'b1;
    @(posedge clk); #1; if16.out_ready = 1'b0;
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic cin, output logic [7:0] s, output logic co,
                        output logic ov, output logic z, output int lat);
    int w;
    w = 0;
    while (!if8.in_ready && w < 20) begin @(posedge clk); #1; w++; end
    @(negedge clk);
    if8.in_valid = 1'b1; if8.a = a; if8.b = b; if8.sub = sub; if8.cin = cin;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    if8.a = 8'($urandom); if8.b = 8'($urandom);
    lat = 0;
    while (!if8.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    s = if8.sum; co = if8.cout; ov = if8.overflow; z = if8.zero;
    @(negedge clk); if8.out_ready = 1'b1;
    @(posedge clk); #1; if8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({if16.in_ready, if16.out_valid, if16.sum, if16.cout, if16.overflow, if16.zero} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset16 got rdy=%b vld=%b sum=%h c=%b v=%b z=%b want rdy=1 vld=0 sum=0000 c=0 v=0 z=0",
               if16.in_ready, if16.out_valid, if16.sum, if16.cout, if16.overflow, if16.zero);
    end
    checks++;
    if ({if8.in_ready, if8.out_valid, if8.sum} !== {1'b1, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL reset8 got rdy=%b vld=%b sum=%h want 1 0 00", if8.in_ready, if8.out_valid, if8.sum);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] va [5], vb [5];
    logic        vs [5], vc [5];
    logic [15:0] s; logic co, ov, z; int lat;
    longint unsigned es; logic eco, eov, ez;
    va = '{16'h1234, 16'hFFFF, 16'h00FF, 16'h8000, 16'h0003};
    vb = '{16'h4321, 16'h0001, 16'h0000, 16'h0001, 16'h0005};
    vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      do_op16(va[i], vb[i], vs[i], vc[i], s, co, ov, z, lat);
      ref_op(16, va[i], vb[i], vs[i], vc[i], es, eco, eov, ez);
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL latency16 case %0d got %0d edges want 4", i, lat);
      end
      checks++;
      if ({s, co, ov, z} !== {es[15:0], eco, eov, ez}) begin
        errors++;
        $display("FAIL directed16 case %0d got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
                 i, s, co, ov, z, es[15:0], eco, eov, ez);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, s; logic sb, ci, co, ov, z; int lat;
    longint unsigned es; logic eco, eov, ez;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom); b = 16'($urandom); sb = 1'($urandom); ci = 1'($urandom);
      if (i % 8 == 0) a = 16'hFFFF;
      if (i % 8 == 1) b = a;
      do_op16(a, b, sb, ci, s, co, ov, z, lat);
      ref_op(16, a, b, sb, ci, es, eco, eov, ez);
      checks++;
      if ({s, co, ov, z} !== {es[15:0], eco, eov, ez} || lat !== 4) begin
        errors++;
        $display("FAIL random16 a=%h b=%h sub=%b cin=%b got sum=%h c=%b v=%b z=%b lat=%0d want sum=%h c=%b v=%b z=%b lat=4",
                 a, b, sb, ci, s, co, ov, z, lat, es[15:0], eco, eov, ez);
      end
    end
  endtask

  task automatic test_backpressure();
    longint unsigned es; logic eco, eov, ez;
    logic [15:0] s; logic co, ov, z; int lat;
    ref_op(16, 16'hABCD, 16'h1234, 1'b0, 1'b1, es, eco, eov, ez);
    @(negedge clk);
    if16.in_valid = 1'b1; if16.a = 16'hABCD; if16.b = 16'h1234; if16.sub = 1'b0; if16.cin = 1'b1;
    @(posedge clk); #1; if16.in_valid = 1'b0;
    lat = 0;
    while (!if16.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if16.in_valid = 1'b1; if16.a = 16'h0000; if16.b = 16'h0000; if16.sub = 1'b0; if16.cin = 1'b0;
      end
      @(posedge clk); #1; if16.in_valid = 1'b0;
      checks++;
      if ({if16.out_valid, if16.in_ready, if16.sum, if16.cout, if16.overflow, if16.zero} !==
          {1'b1, 1'b0, es[15:0], eco, eov, ez}) begin
        errors++;
        $display("FAIL hold cycle %0d got vld=%b rdy=%b sum=%h c=%b v=%b z=%b want vld=1 rdy=0 sum=%h c=%b v=%b z=%b",
                 i, if16.out_valid, if16.in_ready, if16.sum, if16.cout, if16.overflow, if16.zero,
                 es[15:0], eco, eov, ez);
      end
    end
    @(negedge clk); if16.out_ready = 1'b1;
    @(posedge clk); #1; if16.out_ready = 1'b0;
    checks++;
    if ({if16.out_valid, if16.in_ready, if16.sum} !== {1'b0, 1'b1, es[15:0]}) begin
      errors++;
      $display("FAIL release got vld=%b rdy=%b sum=%h want vld=0 rdy=1 sum=%h",
               if16.out_valid, if16.in_ready, if16.sum, es[15:0]);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({if16.out_valid, if16.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL idle_stays got vld=%b rdy=%b want vld=0 rdy=1", if16.out_valid, if16.in_ready);
    end
    do_op16(16'h0F0F, 16'h0101, 1'b1, 1'b0, s, co, ov, z, lat);
    ref_op(16, 16'h0F0F, 16'h0101, 1'b1, 1'b0, es, eco, eov, ez);
    checks++;
    if ({s, co, ov, z} !== {es[15:0], eco, eov, ez}) begin
      errors++;
      $display("FAIL after_bp got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
               s, co, ov, z, es[15:0], eco, eov, ez);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] s; logic co, ov, z; int lat;
    @(negedge clk);
    if16.in_valid = 1'b1; if16.a = 16'h0FFF; if16.b = 16'h0088; if16.sub = 1'b0; if16.cin = 1'b0;
    @(posedge clk); #1; if16.in_valid = 1'b0;
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({if16.in_ready, if16.out_valid, if16.sum, if16.cout, if16.overflow, if16.zero} !== {1'b1, 1'b0, 16'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b vld=%b sum=%h c=%b v=%b z=%b want rdy=1 vld=0 sum=0000 c=0 v=0 z=0",
               if16.in_ready, if16.out_valid, if16.sum, if16.cout, if16.overflow, if16.zero);
    end
    @(negedge clk); rst_n = 1'b1;
    do_op16(16'h0001, 16'h0001, 1'b0, 1'b0, s, co, ov, z, lat);
    checks++;
    if ({s, co, ov, z} !== {16'h0002, 3'b000} || lat !== 4) begin
      errors++;
      $display("FAIL after_reset got sum=%h c=%b v=%b z=%b lat=%0d want sum=0002 c=0 v=0 z=0 lat=4",
               s, co, ov, z, lat);
    end
  endtask

  task automatic test_width8();
    logic [7:0] a, b, s; logic sb, ci, co, ov, z; int lat;
    longint unsigned es; logic eco, eov, ez;
    do_op8(8'h7F, 8'h01, 1'b0, 1'b0, s, co, ov, z, lat);
    checks++;
    if ({s, co, ov} !== {8'h80, 1'b0, 1'b1} || lat !== 2) begin
      errors++;
      $display("FAIL w8_directed got sum=%h c=%b v=%b lat=%0d want sum=80 c=0 v=1 lat=2", s, co, ov, lat);
    end
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom); b = 8'($urandom); sb = 1'($urandom); ci = 1'($urandom);
      do_op8(a, b, sb, ci, s, co, ov, z, lat);
      ref_op(8, a, b, sb, ci, es, eco, eov, ez);
      checks++;
      if ({s, co, ov, z} !== {es[7:0], eco, eov, ez} || lat !== 2) begin
        errors++;
        $display("FAIL random8 a=%h b=%h sub=%b cin=%b got sum=%h c=%b v=%b z=%b lat=%0d want sum=%h c=%b v=%b z=%b lat=2",
                 a, b, sb, ci, s, co, ov, z, lat, es[7:0], eco, eov, ez);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.sub = 1'b0; if16.cin = 1'b0; if16.out_ready = 1'b0;
    if8.in_valid  = 1'b0; if8.a  = '0; if8.b  = '0; if8.sub  = 1'b0; if8.cin  = 1'b0; if8.out_ready  = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
